// File: rtl/pixel_demux.sv
// Round-robin serial-to-parallel demux: out_valid rises the cycle after a group's final word is accepted.
// Only a group's final word can stall, and only while the previous group is unconsumed; DEMUX_STALL_CNT_EN adds stall_count.
module pixel_demux #(
    parameter int mux_width = 2,
    parameter int bus_width = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 in_valid,
    input  logic [bus_width-1:0]                 in,
    output logic                                 in_ready,
    output logic [mux_width-1:0][bus_width-1:0]  out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(mux_width)-1:0]         lane
`ifdef DEMUX_STALL_CNT_EN
    ,
    output logic [15:0]                          stall_count
`endif
);
    localparam int LW = $clog2(mux_width);
    localparam logic [LW-1:0] LAST = LW'(mux_width - 1);

    logic [mux_width-2:0][bus_width-1:0] shadow;
    logic                                last_lane;
    logic                                accept;
    logic                                complete;

    assign last_lane = (lane == LAST);
    assign in_ready  = !reset && !clear && !(last_lane && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && last_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane      <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            shadow    <= '0;
        end else begin
            if (clear) begin
                lane <= '0;
            end else if (complete) begin
                out       <= {in, shadow};
                out_valid <= 1'b1;
                lane      <= '0;
            end else if (accept) begin
                for (int k = 0; k < mux_width - 1; k++) begin
                    if (lane == LW'(k)) begin
                        shadow[k] <= in;
                    end
                end
                lane <= lane + 1'b1;
            end
            // A drain in the same cycle as a completion keeps out_valid high.
            if (out_valid && out_ready && !complete) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_demux.sv
// Bench for pixel_demux: directed scenarios on 2- and 3-lane instances plus a randomized run against a queue model.
module tb_pixel_demux;
    localparam int MA = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic                a_clear = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0]          a_in = 8'd0;
    logic                a_in_ready, a_out_valid;
    logic [1:0][7:0]     a_out;
    logic [0:0]          a_lane;

    logic                b_clear = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0]          b_in = 8'd0;
    logic                b_in_ready, b_out_valid;
    logic [2:0][7:0]     b_out;
    logic [1:0]          b_lane;
`ifdef DEMUX_STALL_CNT_EN
    logic [15:0]         a_stall, b_stall;
`endif

    int total = 0;
    int bad = 0;

    pixel_demux #(.mux_width(2), .bus_width(8)) dut_a (
        .clk(clk), .reset(reset), .clear(a_clear),
        .in_valid(a_in_valid), .in(a_in), .in_ready(a_in_ready),
        .out(a_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .lane(a_lane)
`ifdef DEMUX_STALL_CNT_EN
        , .stall_count(a_stall)
`endif
    );

    pixel_demux #(.mux_width(3), .bus_width(8)) dut_b (
        .clk(clk), .reset(reset), .clear(b_clear),
        .in_valid(b_in_valid), .in(b_in), .in_ready(b_in_ready),
        .out(b_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .lane(b_lane)
`ifdef DEMUX_STALL_CNT_EN
        , .stall_count(b_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 1'b1; a_in = 8'hAA;
        b_in_valid = 1'b1; b_in = 8'h55;
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_a got=%b exp=0", a_in_ready); end
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_b got=%b exp=0", b_in_ready); end
        step(); step();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        total++; if (a_lane !== 1'b0) begin bad++; $display("FAIL reset_lane got=%0d exp=0", a_lane); end
        total++; if (a_out !== 16'h0) begin bad++; $display("FAIL reset_out got=%h exp=0000", a_out); end
        total++; if (b_out !== 24'h0 || b_lane !== 2'd0) begin bad++; $display("FAIL reset_b got out=%h lane=%0d exp 0/0", b_out, b_lane); end
        reset = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
        step();
`ifdef DEMUX_STALL_CNT_EN
        total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", a_stall); end
`endif
    endtask

    task automatic test_basic();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in = 8'd85;
        step();
        a_in = 8'd157;
        step();
        a_in_valid = 1'b0;
        total++; if (a_out[0] !== 8'b01010101) begin bad++; $display("FAIL basic_out0 got=%0d exp=85", a_out[0]); end
        total++; if (a_out[1] !== 8'b10011101) begin bad++; $display("FAIL basic_out1 got=%0d exp=157", a_out[1]); end
        total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", a_out_valid); end
        total++; if (a_lane !== 1'b0) begin bad++; $display("FAIL basic_lane got=%0d exp=0", a_lane); end
        step();
        total++; if (a_out_valid !== 1'b0 || a_out[1] !== 8'd157) begin bad++; $display("FAIL basic_drain got valid=%b out1=%0d exp 0/157", a_out_valid, a_out[1]); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            a_in_valid = 1'b1; a_in = 8'(w);
            step();
        end
        total++; if (a_out_valid !== 1'b1 || a_out !== {8'd2, 8'd1}) begin bad++; $display("FAIL bp_first got valid=%b out=%h exp 1/0201", a_out_valid, a_out); end
        a_in = 8'd4;
        for (int s = 0; s < 5; s++) begin
            #1;
            total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0", s, a_in_ready); end
            step();
        end
        total++; if (a_out !== {8'd2, 8'd1} || a_lane !== 1'b1) begin bad++; $display("FAIL bp_hold got out=%h lane=%0d exp 0201/1", a_out, a_lane); end
`ifdef DEMUX_STALL_CNT_EN
        total++; if (a_stall !== 16'd5) begin bad++; $display("FAIL bp_stall_count got=%0d exp=5", a_stall); end
`endif
        a_out_ready = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", a_in_ready); end
        step();
        a_in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_out !== {8'd4, 8'd3}) begin bad++; $display("FAIL bp_second got valid=%b out=%h exp 1/0403", a_out_valid, a_out); end
        step();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1'b1; a_in = 8'(10 + i);
            #1;
            total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, a_in_ready); end
            step();
            if (i % 2 == 1) begin
                exp = {8'(10 + i), 8'(9 + i)};
                total++; if (a_out_valid !== 1'b1 || a_out !== exp) begin bad++; $display("FAIL b2b_group i=%0d got valid=%b out=%h exp 1/%h", i, a_out_valid, a_out, exp); end
            end else begin
                total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap i=%0d got=%b exp=0", i, a_out_valid); end
            end
        end
        a_in_valid = 1'b0;
        step();
    endtask

    task automatic test_clear();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in = 8'd20;
        step();
        total++; if (a_lane !== 1'b1) begin bad++; $display("FAIL clr_lane_pre got=%0d exp=1", a_lane); end
        a_clear = 1'b1; a_in = 8'd21;
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", a_in_ready); end
        step();
        a_clear = 1'b0;
        total++; if (a_lane !== 1'b0 || a_out_valid !== 1'b0) begin bad++; $display("FAIL clr_post got lane=%0d valid=%b exp 0/0", a_lane, a_out_valid); end
        a_in = 8'd22; step();
        a_in = 8'd23; step();
        a_in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_out !== {8'd23, 8'd22}) begin bad++; $display("FAIL clr_group got valid=%b out=%h exp 1/1716", a_out_valid, a_out); end
        step();
    endtask

    task automatic test_mux3();
        logic [23:0] exp;
        b_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1; b_in = 8'(i + 1);
            #1;
            total++; if (b_lane !== 2'(i % 3)) begin bad++; $display("FAIL m3_lane i=%0d got=%0d exp=%0d", i, b_lane, i % 3); end
            step();
            if (i % 3 == 2) begin
                exp = {8'(i + 1), 8'(i), 8'(i - 1)};
                total++; if (b_out_valid !== 1'b1 || b_out !== exp) begin bad++; $display("FAIL m3_group i=%0d got valid=%b out=%h exp 1/%h", i, b_out_valid, b_out, exp); end
            end
        end
        b_in_valid = 1'b0;
        total++; if (b_lane !== 2'd0) begin bad++; $display("FAIL m3_lane_end got=%0d exp=0", b_lane); end
        step();
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        for (int w = 5; w <= 7; w++) begin
            a_in_valid = 1'b1; a_in = 8'(w);
            step();
        end
        a_in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_lane !== 1'b1) begin bad++; $display("FAIL rmid_pre got valid=%b lane=%0d exp 1/1", a_out_valid, a_lane); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (a_out_valid !== 1'b0 || a_lane !== 1'b0 || a_out !== 16'h0) begin bad++; $display("FAIL rmid_post got valid=%b lane=%0d out=%h exp 0/0/0000", a_out_valid, a_lane, a_out); end
`ifdef DEMUX_STALL_CNT_EN
        total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL rmid_stall got=%0d exp=0", a_stall); end
`endif
        a_out_ready = 1'b1;
        step();
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rmid_nothing got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_random();
        logic [7:0]  cur[$];
        logic [15:0] grp;
        bit          pend;
        bit          exp_rdy, acc, done;
        int          stall;
        cur.delete(); grp = '0; pend = 0; stall = 0;
        for (int c = 0; c < 600; c++) begin
            a_clear     = ($urandom_range(0, 15) == 0);
            a_in_valid  = ($urandom_range(0, 9) < 7);
            a_in        = 8'($urandom);
            a_out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = !a_clear && !(cur.size() == MA - 1 && pend && !a_out_ready);
            total++; if (a_in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, a_in_ready, exp_rdy); end
            total++; if (a_out_valid !== pend) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, a_out_valid, pend); end
            total++; if (a_lane !== 1'(cur.size())) begin bad++; $display("FAIL rnd_lane c=%0d got=%0d exp=%0d", c, a_lane, cur.size()); end
            if (pend) begin
                total++; if (a_out !== grp) begin bad++; $display("FAIL rnd_out c=%0d got=%h exp=%h", c, a_out, grp); end
            end
`ifdef DEMUX_STALL_CNT_EN
            total++; if (a_stall !== 16'(stall)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, a_stall, stall); end
`endif
            acc  = a_in_valid && exp_rdy;
            done = 0;
            if (a_in_valid && !exp_rdy && stall < 65535) stall++;
            if (a_clear) begin
                cur.delete();
            end else if (acc) begin
                cur.push_back(a_in);
                if (cur.size() == MA) begin
                    for (int k = 0; k < MA; k++) grp[k*8 +: 8] = cur[k];
                    cur.delete();
                    done = 1;
                end
            end
            if (done) pend = 1;
            else if (pend && a_out_ready) pend = 0;
            step();
        end
        a_in_valid = 1'b0; a_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_mux3();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_demux.md
Name: pixel_demux

Overview:
- Serial-to-parallel demultiplexer and the inverse of the mux stage.
- Accepts a stream of bus_width-bit pixel words on one input bus and distributes them round-robin into mux_width lanes.
- Presents the assembled group as one packed parallel word with a valid/ready handshake.
- Sits between the sensor readout serialiser and wide downstream consumers such as a line buffer or packer.

Parameters:
- mux_width, 2, number of lanes per group; legal range is 2 or more; non-power-of-two values are legal.
- bus_width, 8, width of each pixel word in bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous group restart; discards any partially filled group.
- in_valid  in  1  input word present.
- in  in  bus_width  input pixel word.
- in_ready  out  1  block accepts `in` this cycle.
- out  out  [mux_width][bus_width]  assembled group; out[k] holds the k-th word accepted in the group.
- out_valid  out  1  `out` holds a complete group.
- out_ready  in  1  consumer takes `out` this cycle.
- lane  out  $clog2(mux_width)  index of the next lane to be written.
- stall_count  out  16  present only with DEMUX_STALL_CNT_EN.

Behaviour:
- Reset (synchronous, active-high, checked on the clk edge):
  - lane=0, out_valid=0, out=0, shadow register=0, stall_count=0.
  - in_ready is 0 while reset is high.
- Internal storage:
  - shadow register holds lanes 0..mux_width-2 of the group being filled.
  - out register holds the last completed group.
- Accept condition: in_valid && in_ready.
- in_ready = !reset && !clear && !(lane==mux_width-1 && out_valid && !out_ready).
  - Only the final word of a group can stall, and only while the previous group is still unconsumed.
- On accept with lane<mux_width-1:
  - shadow[lane] <= in.
  - lane <= lane+1.
- On accept with lane==mux_width-1:
  - out[0..mux_width-2] <= shadow.
  - out[mux_width-1] <= in.
  - out_valid <= 1.
  - lane <= 0 (wraps exactly at mux_width-1, not at a power of two).
- Output drain:
  - out_valid && out_ready with no completion in the same cycle: out_valid <= 0; out data holds its value.
  - Completion and drain in the same cycle: out_valid stays 1 and out takes the new group (back-to-back groups, no bubble).
- Latency: out_valid rises on the clk edge that accepts the final word of the group and is visible the following cycle.
- Throughput: one word per cycle sustained when out_ready is held high.
- out and out_valid are stable while out_valid=1 and out_ready=0.
- clear:
  - lane <= 0; the shadow contents become don't-care.
  - out and out_valid are unaffected.
  - A word presented in the same cycle is not accepted (in_ready=0).
- Reset mid-group or with a pending output: all state is discarded and nothing is emitted.
- in is ignored when in_valid=0.
- lane does not move without an accept.

Optional Feature:
- Macro: DEMUX_STALL_CNT_EN.
- Defined:
  - Adds the stall_count port, a 16-bit saturating counter.
  - Increments each cycle with in_valid=1 && in_ready=0 && reset=0, including clear cycles.
  - Holds at 65535; cleared only by reset.
- Undefined:
  - No port and no counter logic.
  - All other behaviour is identical.

Test Plan:
1. mux_width=2, bus_width=8, out_ready=1, reset high 1 cycle, then in=85 and in=157 on consecutive cycles -> next cycle out[0]=8'b01010101, out[1]=8'b10011101, out_valid=1, lane=0.
2. out_ready=0, send 4 words 1,2,3,4 -> first group {1,2} held; in_ready=0 while word 4 is presented; raise out_ready -> {1,2} drained, then word 4 accepted, then out={3,4}.
3. Continuous stream 10,11,12,13,14,15 with out_ready=1 -> out_valid high on 3 consecutive group cycles with {10,11}, {12,13}, {14,15}; in_ready never low.
4. Send 20, assert clear with 21 present, then send 22 and 23 -> out={22,23}; words 20 and 21 are never emitted.
5. mux_width=3: send 1..6 -> groups {1,2,3} and {4,5,6}; lane sequence 0,1,2,0,1,2,0.
6. With DEMUX_STALL_CNT_EN, repeat scenario 2 with a 5-cycle stall -> stall_count=5; assert reset -> stall_count=0, out_valid=0, lane=0.
